// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encoding and the byte-to-word address shift.
// Optional feature macro: MEM_ACCESS_RMW_EN (read-modify-write sub-word stores).
package mem_access_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
`ifdef MEM_ACCESS_RMW_EN
    ,
    ST_RMW_RD  = 3'd5,
    ST_RMW_WR  = 3'd6
`endif
  } state_e;

  // Byte address to RAM word address
  function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
    return DATA_W'(byte_addr >> WORD_SHIFT);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension,
// sub-word store merge into an existing word, and alignment/size check.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [15:0]       i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merge_data,
  output logic              o_misalign
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [4:0]        w_byte_sh;
  logic [4:0]        w_half_sh;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_ins;

  // Lane shift amounts (little-endian)
  assign w_byte_sh = {i_addr_lo, 3'b000};
  assign w_half_sh = {i_addr_lo[1], 4'b0000};
  assign w_byte    = 8'(i_rdata >> w_byte_sh);
  assign w_half    = 16'(i_rdata >> w_half_sh);

  // Load extraction and extension
  always_comb begin
    o_load_data = i_rdata;
    case (i_size)
      MEM_SIZE_B: o_load_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      MEM_SIZE_H: o_load_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default:    o_load_data = i_rdata;
    endcase
  end

  // Store merge: replace the target lane of the old word
  always_comb begin
    w_mask = '0;
    w_ins  = '0;
    case (i_size)
      MEM_SIZE_B: begin
        w_mask = DATA_W'(32'h0000_00FF << w_byte_sh);
        w_ins  = DATA_W'(DATA_W'(i_wdata[7:0]) << w_byte_sh);
      end
      MEM_SIZE_H: begin
        w_mask = DATA_W'(32'h0000_FFFF << w_half_sh);
        w_ins  = DATA_W'(DATA_W'(i_wdata) << w_half_sh);
      end
      default: begin
        w_mask = '0;
        w_ins  = '0;
      end
    endcase
    o_merge_data = (i_rdata & ~w_mask) | (w_ins & w_mask);
  end

  // Illegal size or natural-alignment violation
  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      MEM_SIZE_B: o_misalign = 1'b0;
      MEM_SIZE_H: o_misalign = i_addr_lo[0];
      MEM_SIZE_W: o_misalign = (i_addr_lo != 2'b00);
      default:    o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between execute stage and single-port word RAM.
// One request per handshake in IDLE; single-cycle response pulse.
// Optional macro MEM_ACCESS_RMW_EN: builds read-modify-write sub-word stores;
// without it, sub-word stores are answered with an error.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            r_state;
  logic              r_ready;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_addr_lo;
  logic [15:0]       r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [DATA_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_merge_sel;

  logic [1:0]        w_size;
  logic [1:0]        w_addr_lo;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merge_data;
  logic              w_misalign;
  logic              w_accept_err;

  // Lane logic sees the live request in IDLE, the latched one afterwards
  assign w_size    = (r_state == ST_IDLE) ? req_size      : r_size;
  assign w_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;

  mem_lane_align u_lane (
    .i_size       (w_size),
    .i_addr_lo    (w_addr_lo),
    .i_signed     (r_signed),
    .i_rdata      (ram_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data),
    .o_misalign   (w_misalign)
  );

  // Acceptance-time error: bad size/alignment, or sub-word store without RMW support
`ifdef MEM_ACCESS_RMW_EN
  assign w_accept_err = w_misalign;
`else
  assign w_accept_err = w_misalign | (req_write & (req_size != MEM_SIZE_W));
`endif

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign ram_addr   = r_ram_addr;
  assign ram_we     = r_ram_we;
  // RMW write data merges the read word in the same cycle it arrives from the RAM
  assign ram_wdata  = r_merge_sel ? w_merge_data : r_ram_wdata;

  // Request FSM with registered RAM and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_write      <= 1'b0;
      r_size       <= MEM_SIZE_B;
      r_signed     <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_ld_data    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= 1'b0;
      r_merge_sel  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ram_we     <= 1'b0;
      r_merge_sel  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ready   <= 1'b0;
            r_write   <= req_write;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            r_ld_data <= '0;
            r_err     <= w_accept_err;
            if (w_accept_err) begin
              r_state <= ST_RESP;
            end else if (!req_write) begin
              r_ram_addr <= word_addr(req_addr);
              r_state    <= ST_RD;
            end else if (req_size == MEM_SIZE_W) begin
              r_ram_addr  <= word_addr(req_addr);
              r_ram_wdata <= req_wdata;
              r_ram_we    <= 1'b1;
              r_state     <= ST_WR;
            end else begin
`ifdef MEM_ACCESS_RMW_EN
              r_ram_addr <= word_addr(req_addr);
              r_state    <= ST_RMW_RD;
`else
              r_state    <= ST_RESP;
`endif
            end
          end
        end
        ST_RD:      r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_ld_data <= w_load_data;
          r_state   <= ST_RESP;
        end
        ST_WR:      r_state <= ST_RESP;
`ifdef MEM_ACCESS_RMW_EN
        ST_RMW_RD: begin
          r_ram_we    <= 1'b1;
          r_merge_sel <= 1'b1;
          r_state     <= ST_RMW_WR;
        end
        ST_RMW_WR:  r_state <= ST_RESP;
`endif
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= r_ld_data;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// requests checked against a byte-array memory model. Honours MEM_ACCESS_RMW_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];
  logic        mem_clr = 1'b1;
  logic [7:0]  ref_b [0:255];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  // Single-port RAM: synchronous write and registered read every edge
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic w, input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = (sz == 2'b11) || ((a % nbytes(sz)) != 0);
`ifndef MEM_ACCESS_RMW_EN
    if (w && sz != 2'b10) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a[7:0]) + i]) << (8 * i));
    if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_b[idx * 4 + i]) << (8 * i));
    return v;
  endfunction

  // Issue one request, follow it to its response and update the model
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_we;
    int          lat;
    int          we_cnt;
    logic        got_err;
    logic [31:0] got_rdata;
    e_err   = model_err(w, sz, a);
    e_rdata = (w || e_err) ? 32'd0 : model_load(sz, sg, a);
    e_lat   = e_err ? 1 : (!w ? 3 : (sz == 2'b10 ? 2 : 3));
    e_we    = (w && !e_err) ? 1 : 0;

    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0;
    we_cnt = 0;
    while (!resp_valid && lat < 12) begin
      if (ram_we) begin
        we_cnt++;
        check("we_addr", ram_addr, {2'b00, a[31:2]});
      end
      @(posedge clk);
      #1;
      lat++;
    end
    got_err   = resp_err;
    got_rdata = resp_rdata;
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_err", {31'd0, got_err}, {31'd0, e_err});
    check("resp_rdata", got_rdata, e_rdata);
    check("we_count", 32'(we_cnt), 32'(e_we));
    @(posedge clk);
    #1;
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);

    if (w && !e_err) begin
      for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a[7:0]) + i] = 8'(wd >> (8 * i));
    end
    check("mem_word", mem[a[7:2]], model_word(int'(a[7:2])));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_b[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // Word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h1C, 32'hDEAD_BEEF);
    check("word7", mem[7], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);

    // Byte/halfword extraction and extension
    do_req(1'b1, 2'b10, 1'b0, 32'h6C, 32'h80FF_7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h6D, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h6E, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h6F, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h6E, 32'h0);

    // Sub-word stores
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h5555_55AA);
`ifdef MEM_ACCESS_RMW_EN
    check("rmw_byte", mem[8], 32'h1122_AA44);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
    check("rmw_half", mem[8], 32'hBEEF_AA44);
`else
    check("norm_byte", mem[8], 32'h1122_3344);
`endif

    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFF_FFFF);

    // Reset during RD_WAIT abandons the load
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h1C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);

    // Random traffic against the byte model
    for (int k = 0; k < 150; k++) begin
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      w  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sg = 1'($urandom);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~32'(nbytes(sz) - 1);
      do_req(w, sz, sg, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the processor's execute stage and the single-port 32-bit word RAM. Accepts one byte-addressed load or store per valid/ready handshake. Translates it into RAM word accesses (addr, data, write enable, registered read data), then returns a single-cycle response. Handles byte/halfword lane extraction, sign extension and alignment checking.

## Interface
- No parameters; the data and address width is fixed at 32.
- clk  in  1  sole clock, rising edge
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high exactly when state is IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request complete
- resp_err  out  1  qualified by resp_valid: misaligned or illegal request
- resp_rdata  out  32  load result; 0 for stores and errors
- ram_addr  out  32  word address = req_addr[31:2]
- ram_wdata  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  32  RAM data_out; valid one clk edge after ram_addr is presented

## Operation
- The RAM writes at the rising edge when ram_we=1. It registers mem[ram_addr] into ram_rdata at every rising edge.
- Lanes are little-endian: byte k = bits [8k+7:8k], k = req_addr[1:0]. Halfword uses bits [15:0] or [31:16], selected by addr[1].
- Error cases, detected at acceptance:
  - size 11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
- An error request goes to RESP with resp_err=1. No RAM write is issued.
- States: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid & req_ready, latch the request.
  - error → RESP
  - load → RD
  - word store → WR
  - sub-word store → RMW_RD
- RD: ram_addr is driven. → RD_WAIT.
- RD_WAIT: ram_rdata is valid. Extract the lane, then zero- or sign-extend it. → RESP.
- WR: ram_we=1, ram_wdata=req_wdata. → RESP.
- RMW_RD: ram_addr is driven, ram_we=0. → RMW_WR.
- RMW_WR: ram_we=1, ram_wdata = ram_rdata with the target lane replaced by req_wdata[7:0] or [15:0]. → RESP.
- RESP: resp_valid=1. → IDLE.
- The request is taken only in IDLE, so back-to-back requests are accepted every (latency+1) cycles.
- req_* inputs are ignored outside IDLE.
- rst sampled high forces the following:
  - state IDLE
  - ram_we=0, ram_addr=0, ram_wdata=0
  - resp_valid=0, resp_err=0, resp_rdata=0
  - req_ready=1 from the next cycle
- Reset mid-operation abandons the request with no response. A ram_we already high in the cycle where rst is sampled still writes at that edge.

## Timing
- Acceptance edge = E. All ram_* and resp_* outputs are registered.
- Load: ram_addr valid after E. RAM samples at E+1. resp_valid is high in the cycle after E+3.
- Word store: ram_we high in the cycle after E. RAM writes at E+1. resp_valid after E+2.
- Sub-word store (RMW): ram_we high in the cycle after E+1. Write at E+2. resp_valid after E+3.
- Error: resp_valid after E+1.
- The next request can be accepted at the edge ending the resp_valid cycle.
- ram_we is never high for more than one cycle per request.

## Configuration
- MEM_ACCESS_RMW_EN defined: sub-word stores use RMW_RD/RMW_WR as described.
- MEM_ACCESS_RMW_EN undefined:
  - RMW states are not built.
  - An aligned sub-word store is reported as an error: resp_err=1 after E+1, with no RAM write.
  - Sub-word loads are unaffected.

## Structure
- Shared include mem_defs.v holds:
  - size encodings (MEM_SIZE_B/H/W)
  - state encodings
  - the word-address shift
- One combinational sub-module, mem_lane_align, is natural. It provides:
  - load lane extraction + sign/zero extension
  - store lane merge
  - the alignment-error check

## Test plan
- Word store 0xDEADBEEF @0x1C, then word load @0x1C → ram_we one cycle, write to word 7. Load resp_rdata=0xDEADBEEF, resp_err=0, at E+3.
- Word 0x80FF7F01 @0x6C. Signed byte load @0x6D → 0x0000007F. Signed byte load @0x6E → 0xFFFFFFFF. Unsigned byte load @0x6F → 0x00000080. Signed halfword load @0x6E → 0xFFFF80FF.
- RMW_EN on: word 0x11223344 @0x20. Byte store 0xAA @0x21 → word becomes 0x1122AA44. Halfword store 0xBEEF @0x22 → 0xBEEFAA44. resp_valid at E+3 each.
- RMW_EN off: byte store @0x21 → resp_err=1 at E+1, word unchanged.
- Misaligned word load @0x06, halfword store @0x03, size 11 → resp_err=1, resp_rdata=0, ram_we never high.
- Assert rst during RD_WAIT of a load → no resp_valid, req_ready=1 the next cycle. A following word load returns correct data.
